// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader.
// Holds the format codes, the word written for an illegal format, RV32I opcode constants,
// the loader FSM state type and a small immediate range-check helper.
package instr_encoder_loader_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // True when v[31:msb] are all equal, i.e. v is representable as a signed (msb+1)-bit value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_core.sv
// Combinational RV32I encoder: packs decoded fields into a 32-bit instruction word.
// Ports:
//   fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i : decoded fields
//   word_o      : encoded instruction (NopWord for an illegal format)
//   illegal_o   : format code 6 or 7
//   range_err_o : immediate does not fit the format; word_o holds the truncated bits
module instr_encoder_core #(
  parameter logic [31:0] NopWord = instr_encoder_loader_pkg::NOP_WORD
) (
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_err_o
);
  import instr_encoder_loader_pkg::*;

  always_comb begin
    word_o      = NopWord;
    illegal_o   = 1'b0;
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_err_o = !fits_signed(imm_i, 11);
      end
      FMT_S: begin
        word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_err_o = !fits_signed(imm_i, 11);
      end
      FMT_B: begin
        word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                       opcode_i};
        range_err_o = !fits_signed(imm_i, 12) || imm_i[0];
      end
      FMT_U: begin
        word_o      = {imm_i[31:12], rd_i, opcode_i};
        range_err_o = |imm_i[11:0];
      end
      FMT_J: begin
        word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        range_err_o = !fits_signed(imm_i, 20) || imm_i[0];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts decoded field bundles over a valid/ready stream,
// encodes each to an RV32I word and writes count words sequentially to imem from base_addr.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, base_addr, count    : begin a load (honoured only when idle)
//   in_valid/in_ready + fields : decoded instruction stream
//   wr_valid/wr_ready, wr_addr, wr_data : imem write port (single output register)
//   busy, done, err            : status; err is sticky until the next start
module instr_encoder_loader #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = instr_encoder_loader_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import instr_encoder_loader_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_range_err;
  logic        wr_fire;
  logic        accept;

  instr_encoder_core #(
    .NopWord (NOP_WORD)
  ) u_core (
    .fmt_i       (fmt),
    .opcode_i    (opcode),
    .rd_i        (rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .imm_i       (imm),
    .word_o      (enc_word),
    .illegal_o   (enc_illegal),
    .range_err_o (enc_range_err)
  );

  assign wr_fire = wr_valid_q && wr_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Word-align the base; low address bits are dropped, not flagged.
          addr_d      = base_addr & ~ADDR_W'(3);
          remaining_d = count;
          err_d       = 1'b0;
          state_d     = (count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // The output register can take a new word when empty or emptying this cycle.
        in_ready = !wr_valid_q || wr_ready;
        accept   = in_valid && in_ready;
        if (wr_fire) begin
          wr_valid_d = 1'b0;
        end
        if (accept) begin
          wr_valid_d  = 1'b1;
          wr_data_d   = enc_word;
          wr_addr_d   = addr_q;
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = remaining_q - CNT_W'(1);
          err_d       = err_q | enc_illegal | enc_range_err;
          if (remaining_q == CNT_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (wr_fire) begin
          wr_valid_d = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: table of field bundles with hand-encoded
// words, streamed through loads of various sizes, plus directed multi-cycle sequences.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  instr_encoder_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im, input logic [31:0] w,
                              input logic e);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.f3 = f3; v.f7 = f7; v.imm = im; v.word = w; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  // Called at posedge+1; returns at posedge+1 with the load started.
  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams tbl[first +: n] with wr_ready held high and checks every write, the done pulse
  // and the final sticky err. Called and returns at posedge+1.
  task automatic stream(input logic [31:0] base, input int first, input int n);
    int sent = 0, got = 0, dones = 0, cyc = 0;
    bit drop = 1'b0, eerr = 1'b0;
    logic [31:0] b, ea;
    b = base & 32'hFFFF_FFFC;
    wr_ready = 1'b1;
    while (dones == 0 && cyc < 100) begin
      if (sent < n) begin drive(tbl[first+sent]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (wr_valid) begin
        if (got < n) begin
          ea = b + 32'(4 * got);
          check("wr_addr", wr_addr, ea);
          check("wr_data", wr_data, tbl[first+got].word);
        end else begin
          check("write_count", 32'(got + 1), 32'(n));
        end
        got++;
      end
      if (sent < n && !in_ready) drop = 1'b1;
      if (in_valid && in_ready) begin eerr |= tbl[first+sent].err; sent++; end
      if (done) dones++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("done_seen", 32'(dones), 32'd1);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("words_written", 32'(got), 32'(n));
    check("in_ready_held", 32'(drop), 32'd0);
    check("err_sticky", 32'(err), 32'(eerr));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h0050_0093, 1'b0);
    tbl[1]  = mk(FMT_R, OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h0020_81B3, 1'b0);
    tbl[2]  = mk(FMT_S, STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020_A423, 1'b0);
    tbl[3]  = mk(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    tbl[4]  = mk(FMT_U, LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    tbl[5]  = mk(FMT_I, OP_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0113, 1'b0);
    tbl[6]  = mk(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,        32'h0020_8463, 1'b0);
    tbl[7]  = mk(FMT_S, STORE,  5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE53_2E23, 1'b0);
    tbl[8]  = mk(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFF9F_F0EF, 1'b0);
    tbl[9]  = mk(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h0010_00EF, 1'b0);
    tbl[10] = mk(FMT_R, OP,     5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0,       32'h4073_02B3, 1'b0);
    tbl[11] = mk(FMT_J, JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h0000_006F, 1'b0);
    tbl[12] = mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h8000_0093, 1'b1);
    tbl[13] = mk(3'd7,  OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h0000_0013, 1'b1);
    tbl[14] = mk(3'd6,  LUI,    5'd9, 5'd4, 5'd4, 3'd1, 7'd1, 32'd77,       32'h0000_0013, 1'b1);
    tbl[15] = mk(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h0000_0163, 1'b1);
    tbl[16] = mk(FMT_U, LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678, 32'h1234_52B7, 1'b1);
    tbl[17] = mk(FMT_J, JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_006F, 1'b1);
    tbl[18] = mk(FMT_S, STORE,  5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'd2048,     32'h8000_2023, 1'b1);
    tbl[19] = tbl[0];

    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    wr_ready = 1'b1;
    drive(tbl[0]);
    #3;
    check("reset_status", {27'b0, in_ready, wr_valid, busy, done, err}, 32'd0);
    check("reset_wr_addr", wr_addr, 32'd0);
    check("reset_wr_data", wr_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word at 0x100.
    do_start(32'h100, 16'd1);
    stream(32'h100, 0, 1);

    // Ten words back-to-back from address 0.
    do_start(32'h0, 16'd10);
    stream(32'h0, 1, 10);

    // Output stall: jal x0,0 held for three cycles with a second bundle waiting.
    do_start(32'h600, 16'd2);
    wr_ready = 1'b0;
    drive(tbl[11]); in_valid = 1'b1;
    #1;
    check("stall_first_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(tbl[0]);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_wr_valid", 32'(wr_valid), 32'd1);
      check("stall_wr_addr", wr_addr, 32'h600);
      check("stall_wr_data", wr_data, 32'h0000_006F);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_wr_data", wr_data, 32'h0000_006F);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("second_wr_addr", wr_addr, 32'h604);
    check("second_wr_data", wr_data, 32'h0050_0093);
    check("second_wr_valid", 32'(wr_valid), 32'd1);
    @(posedge clk); #2;
    check("stall_done", 32'(done), 32'd1);
    check("stall_no_write", 32'(wr_valid), 32'd0);
    @(posedge clk); #2;
    check("stall_done_once", 32'(done), 32'd0);
    check("stall_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Range and format errors, each as its own single-word load at a misaligned base.
    for (int i = 12; i <= 18; i++) begin
      do_start(32'h2002 + 32'(i * 16), 16'd1);
      stream(32'h2002 + 32'(i * 16), i, 1);
    end
    // A fresh start clears err; err then stays set across a following legal word.
    do_start(32'h300, 16'd1);
    stream(32'h300, 0, 1);
    do_start(32'h400, 16'd2);
    stream(32'h400, 18, 2);

    // count == 0: DONE right after start, nothing written.
    do_start(32'h700, 16'd0);
    #1;
    check("zero_done", 32'(done), 32'd1);
    check("zero_no_write", 32'(wr_valid), 32'd0);
    @(posedge clk); #2;
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_idle", 32'(busy), 32'd0);
    check("zero_still_no_write", 32'(wr_valid), 32'd0);
    @(posedge clk); #1;

    // start during RUN is ignored.
    do_start(32'h40, 16'd2);
    start = 1'b1; base_addr = 32'h800; count = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    stream(32'h40, 1, 2);

    // Address wrap.
    do_start(32'hFFFF_FFFC, 16'd2);
    stream(32'hFFFF_FFFC, 1, 2);

    // Reset mid-load after one of three words.
    do_start(32'h0, 16'd3);
    wr_ready = 1'b1;
    drive(tbl[13]); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("pre_reset_err", 32'(err), 32'd1);
    check("pre_reset_wr_valid", 32'(wr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_status", {27'b0, in_ready, wr_valid, busy, done, err}, 32'd0);
    check("midrst_wr_addr", wr_addr, 32'd0);
    check("midrst_wr_data", wr_data, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(32'h900, 16'd1);
    stream(32'h900, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
